// File: rtl/soc_bus_defs.sv
// Shared bus definitions for the I/O port arbiter: FSM encoding, command
// bundle, error data default and request decode.
package soc_bus_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hFFFF_FFFF;

  // One master's command as presented to the arbiter.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wr;
    logic        rd;
  } bus_cmd_t;

  // A master requests when it reads or writes any byte lane.
  function automatic logic bus_req(input logic rd, input logic [3:0] wr);
    return rd | (|wr);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way picker: round-robin on contention (favours the master that was
// not served last) or fixed priority with master 0 always winning.
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed,
  output logic       winner
);

  // Winner select; a lone requester always wins regardless of mode.
  always_comb begin
    winner = 1'b0;
    if (fixed) begin
      winner = ~req[0] & req[1];
    end else begin
      case (req)
        2'b01:   winner = 1'b0;
        2'b10:   winner = 1'b1;
        2'b11:   winner = ~last;
        default: winner = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares the single SoC I/O port between CPU (m0) and DMA (m1). One
// transaction in flight, registered grant, timeout with error response.
module io_bus_arbiter
  import soc_bus_defs::*;
#(
  parameter string       ARB_MODE       = "ROUND_ROBIN",
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic [3:0]  m0_wr_i,
  input  logic        m0_rd_i,
  output logic [31:0] m0_data_o,
  output logic        m0_accept_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  input  logic [3:0]  m1_wr_i,
  input  logic        m1_rd_i,
  output logic [31:0] m1_data_o,
  output logic        m1_accept_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] io_addr_o,
  output logic [31:0] io_data_o,
  output logic [3:0]  io_wr_o,
  output logic        io_rd_o,
  input  logic [31:0] io_data_i,
  input  logic        io_accept_i,
  input  logic        io_ack_i
);

  localparam logic        FIXED_MODE = (ARB_MODE == "FIXED");
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYCLES - 1);

  bus_cmd_t [1:0]   cmd;
  logic [1:0]       req;
  arb_state_t       state, state_nx;
  logic             grant_q, grant_nx;
  logic             last_q, last_nx;
  logic             winner;
  logic [15:0]      cnt_q, cnt_nx;
  logic             accept;
  logic             cap_en, cap_err;
  logic [31:0]      cap_data;
  logic [1:0][31:0] rdata_q;
  logic [1:0]       ack_q, err_q;

  assign cmd[0] = {m0_addr_i, m0_data_i, m0_wr_i, m0_rd_i};
  assign cmd[1] = {m1_addr_i, m1_data_i, m1_wr_i, m1_rd_i};
  assign req[0] = bus_req(m0_rd_i, m0_wr_i);
  assign req[1] = bus_req(m1_rd_i, m1_wr_i);

  arb_rr2 u_pick (
    .req    (req),
    .last   (last_q),
    .fixed  (FIXED_MODE),
    .winner (winner)
  );

  // Next-state, slave-side muxing and response capture decisions.
  always_comb begin
    state_nx  = state;
    grant_nx  = grant_q;
    last_nx   = last_q;
    cnt_nx    = cnt_q;
    accept    = 1'b0;
    cap_en    = 1'b0;
    cap_err   = 1'b0;
    cap_data  = io_data_i;
    io_addr_o = '0;
    io_data_o = '0;
    io_wr_o   = '0;
    io_rd_o   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          grant_nx = winner;
          state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!req[grant_q]) begin
          // Master withdrew before the slave took the command: abandon it.
          state_nx = ST_IDLE;
        end else begin
          io_addr_o = cmd[grant_q].addr;
          io_data_o = cmd[grant_q].data;
          io_wr_o   = cmd[grant_q].wr;
          io_rd_o   = cmd[grant_q].rd & ~(|cmd[grant_q].wr);
          if (io_accept_i) begin
            accept = 1'b1;
            cnt_nx = '0;
            if (io_ack_i) begin
              cap_en   = 1'b1;
              state_nx = ST_RESP;
            end else begin
              state_nx = ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        cnt_nx = cnt_q + 16'd1;
        if (io_ack_i) begin
          // A real ack beats a simultaneous timeout.
          cap_en   = 1'b1;
          state_nx = ST_RESP;
        end else if (cnt_q == TO_LAST) begin
          cap_en   = 1'b1;
          cap_err  = 1'b1;
          cap_data = ERR_DATA;
          state_nx = ST_RESP;
        end
      end
      ST_RESP: begin
        last_nx  = grant_q;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM state, grant, round-robin history and timeout counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state   <= state_nx;
      grant_q <= grant_nx;
      last_q  <= last_nx;
      cnt_q   <= cnt_nx;
    end
  end

  // Response registers: one-cycle ack toward the granted master, data held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      if (cap_en) begin
        ack_q[grant_q]   <= 1'b1;
        err_q[grant_q]   <= cap_err;
        rdata_q[grant_q] <= cap_data;
      end
    end
  end

  assign m0_accept_o = accept & ~grant_q;
  assign m1_accept_o = accept & grant_q;
  assign m0_ack_o    = ack_q[0];
  assign m1_ack_o    = ack_q[1];
  assign m0_err_o    = err_q[0];
  assign m1_err_o    = err_q[1];
  assign m0_data_o   = rdata_q[0];
  assign m1_data_o   = rdata_q[1];

endmodule
